// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight write scoreboard with operand forwarding and load-use interlock (optional FWD_PERF_CNT_EN counters)
module fwd_scoreboard #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int DEPTH  = 3,
   parameter int N_READ = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       issue_valid,
   input  logic                       issue_wr_en,
   input  logic [REG_AW-1:0]          issue_wr_addr,
   input  logic                       flush,
   input  logic [N_READ-1:0]          rd_en,
   input  logic [N_READ*REG_AW-1:0]   rd_addr,
   input  logic [N_READ*DATA_W-1:0]   rf_data,
   input  logic [DEPTH-1:0]           res_we,
   input  logic [DEPTH*DATA_W-1:0]    res_data,
   output logic [N_READ*DATA_W-1:0]   fwd_data,
   output logic [N_READ-1:0]          fwd_hit,
   output logic                       stall
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]                stall_count,
   output logic [31:0]                fwd_count
`endif
);

   // index k holds pipeline entry k+1; index 0 is the youngest (just issued)
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  ready_q, ready_d;
   logic [REG_AW-1:0] waddr_q [DEPTH];
   logic [REG_AW-1:0] waddr_d [DEPTH];
   logic [DATA_W-1:0] data_q  [DEPTH];
   logic [DATA_W-1:0] data_d  [DEPTH];

   logic [DEPTH-1:0]  avail;
   logic [DATA_W-1:0] value [DEPTH];
   logic [N_READ-1:0] hazard;
   logic              issue_take;

   // per-entry availability, with same-cycle results bypassing the stored data
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         avail[k] = valid_q[k] & (ready_q[k] | res_we[k]);
         value[k] = res_we[k] ? res_data[k*DATA_W +: DATA_W] : data_q[k];
      end
   end

   // read resolution: walk oldest to youngest so the youngest match overrides
   always_comb begin
      fwd_data = rf_data;
      fwd_hit  = '0;
      hazard   = '0;
      for (int p = 0; p < N_READ; p++) begin
         if (rd_en[p]) begin
            for (int k = DEPTH-1; k >= 0; k--) begin
               if (valid_q[k] && (waddr_q[k] == rd_addr[p*REG_AW +: REG_AW])) begin
                  if (avail[k]) begin
                     fwd_data[p*DATA_W +: DATA_W] = value[k];
                     fwd_hit[p]                   = 1'b1;
                     hazard[p]                    = 1'b0;
                  end else begin
                     fwd_data[p*DATA_W +: DATA_W] = rf_data[p*DATA_W +: DATA_W];
                     fwd_hit[p]                   = 1'b0;
                     hazard[p]                    = 1'b1;
                  end
               end
            end
         end
      end
      stall      = (|hazard) & ~flush;
      issue_take = issue_valid & ~stall & ~flush;
   end

   // next scoreboard contents: capture results, shift one stage, insert issue or bubble
   always_comb begin
      valid_d[0] = issue_take & issue_wr_en;
      waddr_d[0] = issue_wr_addr;
      ready_d[0] = 1'b0;
      data_d[0]  = '0;
      for (int k = 1; k < DEPTH; k++) begin
         valid_d[k] = valid_q[k-1];
         waddr_d[k] = waddr_q[k-1];
         ready_d[k] = ready_q[k-1] | (valid_q[k-1] & res_we[k-1]);
         data_d[k]  = (valid_q[k-1] & res_we[k-1]) ? res_data[(k-1)*DATA_W +: DATA_W]
                                                   : data_q[k-1];
      end
      if (flush) begin
         valid_d = '0;
      end
   end

   // scoreboard state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         ready_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            waddr_q[k] <= '0;
            data_q[k]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         ready_q <= ready_d;
         for (int k = 0; k < DEPTH; k++) begin
            waddr_q[k] <= waddr_d[k];
            data_q[k]  <= data_d[k];
         end
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] fwd_count_q, fwd_count_d;
   logic [32:0] fwd_sum;

   // saturating event counters; flush leaves them untouched
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
      fwd_sum = {1'b0, fwd_count_q};
      for (int p = 0; p < N_READ; p++) begin
         fwd_sum = fwd_sum + {32'd0, fwd_hit[p]};
      end
      fwd_count_d = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
   end

   // counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count_q <= '0;
         fwd_count_q   <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         fwd_count_q   <= fwd_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign fwd_count   = fwd_count_q;
`endif

endmodule
